// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit lab ALU.
//   alu_op_t     : operation codes selected by alu_input_ctrl and decoded by the ALU
//   ALU_NUM_OPS  : number of defined operations (default wrap modulus for op_sel)
//   op_wrap_step : one step forward/backward through 0..num_ops-1 with wraparound
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } alu_op_t;

  localparam int ALU_NUM_OPS = 10;

  function automatic logic [3:0] op_wrap_step(input logic [3:0] cur, input logic up,
                                              input int num_ops);
    if (up) return (int'(cur) == num_ops - 1) ? 4'd0 : cur + 4'd1;
    else    return (cur == 4'd0) ? 4'(num_ops - 1) : cur - 4'd1;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: 2-FF synchroniser + debounce FSM for one active-low pushbutton.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   key_n       : raw asynchronous key, low = pressed
//   press_pulse : one-cycle event when a press is accepted (plus auto-repeat steps)
//   held        : debounced level, 1 while the key counts as pressed
// Optional feature macro: ALU_INPUT_CTRL_AUTO_REPEAT_EN (auto-repeat while held).
// REPEAT_CYCLES = 0 disables repeat for an instance even when the macro is defined.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse,
  output logic held
);

  localparam logic [1:0] ST_RELEASED    = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  localparam int              DW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Synchroniser is deliberately not reset: it must keep tracking the real key
  // level through reset so a key held across reset is seen as already down.
  logic r_sync1, r_sync2;
  always_ff @(posedge clk) begin
    r_sync1 <= key_n;
    r_sync2 <= r_sync1;
  end

  logic          w_low;
  logic [1:0]    r_state;
  logic [DW-1:0] r_cnt;
  logic          r_armed;
  logic          r_press_pulse;

  assign w_low = ~r_sync2;

  // r_armed is cleared by reset and only set once the key is seen released,
  // so a key still held when reset drops can never produce an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RELEASED;
      r_cnt         <= '0;
      r_armed       <= 1'b0;
      r_press_pulse <= 1'b0;
    end else begin
      r_press_pulse <= 1'b0;
      if (r_sync2) r_armed <= 1'b1;
      case (r_state)
        ST_RELEASED: begin
          if (w_low) begin
            r_state <= ST_PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!w_low) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state       <= ST_PRESSED;
            r_cnt         <= '0;
            r_press_pulse <= r_armed;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_low) begin
            r_state <= ST_RELEASE_CHK;
            r_cnt   <= '0;
          end
        end
        ST_RELEASE_CHK: begin
          if (w_low) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign held = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_CHK);

`ifdef ALU_INPUT_CTRL_AUTO_REPEAT_EN
  logic w_rpt_pulse;

  if (REPEAT_CYCLES > 0) begin : g_rpt
    localparam int            RW       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_pulse;

    // Counts only while PRESSED and the key is still low; anything else
    // (release starting, other states) restarts the hold interval.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rpt_cnt   <= '0;
        r_rpt_pulse <= 1'b0;
      end else begin
        r_rpt_pulse <= 1'b0;
        if (r_state == ST_PRESSED && w_low) begin
          if (r_rpt_cnt == RPT_LAST) begin
            r_rpt_cnt   <= '0;
            r_rpt_pulse <= r_armed;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
        end else begin
          r_rpt_cnt <= '0;
        end
      end
    end

    assign w_rpt_pulse = r_rpt_pulse;
  end else begin : g_no_rpt
    assign w_rpt_pulse = 1'b0;
  end

  assign press_pulse = r_press_pulse | w_rpt_pulse;
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  assign press_pulse = r_press_pulse;
`endif

endmodule

// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl: pushbutton front end for the 4-bit lab ALU.
//   clk, rst            : clock, synchronous active-high reset
//   key_next_n          : step op_sel forward (active low, async)
//   key_prev_n          : step op_sel backward (active low, async)
//   key_load_n          : latch sw_a/sw_b into op_a/op_b (active low, async)
//   sw_a, sw_b          : operand switches
//   op_sel              : registered operation code, always < NUM_OPS
//   op_a, op_b          : registered operands
//   op_changed          : one-cycle pulse with the first cycle of a new op_sel
//   operands_valid      : one-cycle pulse with the first cycle of newly loaded operands
// Optional feature macro: ALU_INPUT_CTRL_AUTO_REPEAT_EN (next/prev auto-repeat).
module alu_input_ctrl
  import alu_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_OPS         = ALU_NUM_OPS,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_next_n,
  input  logic         key_prev_n,
  input  logic         key_load_n,
  input  logic [N-1:0] sw_a,
  input  logic [N-1:0] sw_b,
  output alu_op_t      op_sel,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         op_changed,
  output logic         operands_valid
);

  logic       w_next_evt, w_prev_evt, w_load_evt;
  logic [2:0] w_held;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_key_next (
    .clk(clk), .rst(rst), .key_n(key_next_n), .press_pulse(w_next_evt), .held(w_held[0])
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_key_prev (
    .clk(clk), .rst(rst), .key_n(key_prev_n), .press_pulse(w_prev_evt), .held(w_held[1])
  );

  // Load never auto-repeats.
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(0)) u_key_load (
    .clk(clk), .rst(rst), .key_n(key_load_n), .press_pulse(w_load_evt), .held(w_held[2])
  );

  // Debounced levels are not needed here; they remain available as debug taps.
  logic w_unused_held;
  assign w_unused_held = ^w_held;

  logic [3:0]   r_op_sel;
  logic [N-1:0] r_op_a, r_op_b;
  logic         r_op_changed, r_operands_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_sel         <= 4'(OP_ADD);
      r_op_a           <= '0;
      r_op_b           <= '0;
      r_op_changed     <= 1'b0;
      r_operands_valid <= 1'b0;
    end else begin
      r_op_changed     <= 1'b0;
      r_operands_valid <= 1'b0;
      // Simultaneous next+prev cancel out.
      if (w_next_evt != w_prev_evt) begin
        r_op_sel     <= op_wrap_step(r_op_sel, w_next_evt, NUM_OPS);
        r_op_changed <= 1'b1;
      end
      if (w_load_evt) begin
        r_op_a           <= sw_a;
        r_op_b           <= sw_b;
        r_operands_valid <= 1'b1;
      end
    end
  end

  assign op_sel         = alu_op_t'(r_op_sel);
  assign op_a           = r_op_a;
  assign op_b           = r_op_b;
  assign op_changed     = r_op_changed;
  assign operands_valid = r_operands_valid;

endmodule

// File: doc/alu_input_ctrl.md
Name: alu_input_ctrl

Overview:
- Front-end stage that feeds the 4-bit lab ALU datapath and its result/flag multiplexer.
- Synchronises and debounces the board pushbuttons, then steps the registered operation selector.
- Latches operands A/B from the switches on command.
- Replaces raw KEY-edge clocking with clean single-cycle events in the clk domain.

Parameters:
- N, 4, operand width.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); must be >= 2.
- NUM_OPS, 10, number of selectable operations; op_sel wraps within 0..NUM_OPS-1.
- REPEAT_CYCLES, 25000000, hold time before and between auto-repeat steps (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  CLOCK_50; single clock domain.
- rst  input  1  synchronous, active-high reset.
- key_next_n  input  1  active-low pushbutton (KEY[0]), asynchronous; advances the operation.
- key_prev_n  input  1  active-low pushbutton (KEY[1]), asynchronous; steps the operation back.
- key_load_n  input  1  active-low pushbutton (KEY[2]), asynchronous; latches operands.
- sw_a  input  N  operand A switches (SW[3:0]).
- sw_b  input  N  operand B switches (SW[7:4]).
- op_sel  output  4  registered operation code (alu_pkg::alu_op_t).
- op_a  output  N  registered operand A.
- op_b  output  N  registered operand B.
- op_changed  output  1  one-cycle pulse in the same cycle op_sel first shows a new value.
- operands_valid  output  1  one-cycle pulse in the same cycle op_a/op_b first show newly loaded values.

Behaviour:
- Reset: op_sel=OP_ADD (0), op_a=0, op_b=0, op_changed=0, operands_valid=0.
- Reset also clears every debounce counter and sets every debounced key level to released (1).
- Reset asserted mid-debounce or mid-hold discards the pending event; no pulse follows reset release.
- Per key: 2-FF synchroniser, then debouncer FSM with states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
- RELEASED -> PRESS_CHK on synced low.
- PRESS_CHK -> PRESSED after DEBOUNCE_CYCLES consecutive low samples; any high sample returns to RELEASED and clears the count.
- PRESS_CHK -> PRESSED transition emits a one-cycle press event.
- PRESSED -> RELEASE_CHK on synced high; RELEASE_CHK -> RELEASED after DEBOUNCE_CYCLES consecutive high samples; any low sample returns to PRESSED.
- The release path emits no event.
- Latency: a clean press first sampled low at edge t updates op_sel/op_a/op_b at edge t+DEBOUNCE_CYCLES+3. The output pulse is high for the following cycle.
- One press yields exactly one step, however long the key is held (without AUTO_REPEAT_EN).
- A glitch shorter than DEBOUNCE_CYCLES yields no event.
- next event: op_sel = (op_sel==NUM_OPS-1) ? 0 : op_sel+1.
- prev event: op_sel = (op_sel==0) ? NUM_OPS-1 : op_sel-1.
- next and prev events in the same cycle: op_sel unchanged and op_changed stays 0.
- load event: op_a<=sw_a, op_b<=sw_b; operands_valid pulses even if the values are unchanged.
- load coincident with next/prev: both updates apply in the same cycle and both pulses assert.
- op_sel never holds a value >= NUM_OPS.

Optional Feature:
- Macro: ALU_INPUT_CTRL_AUTO_REPEAT_EN.
- Defined: while next or prev stays in PRESSED, an extra step event fires after REPEAT_CYCLES of hold and every REPEAT_CYCLES after that. The repeat counter clears on leaving PRESSED and on rst. Wrap rules apply unchanged. The load key never repeats.
- Undefined: no repeat logic or counter is synthesised; exactly one event per press.

Decomposition:
- alu_pkg holds typedef enum logic [3:0] alu_op_t: OP_ADD=0, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR=9.
- alu_pkg also holds localparam ALU_NUM_OPS=10, which is the default source for NUM_OPS.
- Sub-module key_debouncer (params DEBOUNCE_CYCLES, REPEAT_CYCLES; ports clk, rst, key_n, press_pulse, held) holds the synchroniser, debouncer FSM and optional repeat logic. It is instantiated three times.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16):
- rst high 2 cycles, then low -> op_sel=0, op_a=0, op_b=0, no pulses for 20 cycles.
- key_next_n low at edge 0 and held 30 cycles -> op_sel=1 at edge 7, op_changed high only for cycle 7, no further step (macro undefined).
- key_next_n low for 3 cycles then high -> op_sel stays 0, no pulse.
- 10 clean next presses from 0 -> op_sel 1..9 then 0; prev press at 0 -> op_sel=9.
- sw_a=4'hA, sw_b=4'h3, clean load press simultaneous with next and prev presses -> op_a=A, op_b=3, operands_valid pulses once, op_sel unchanged, op_changed=0.
- next held and rst pulsed at edge 5 -> no op_changed after reset; with macro defined, next held 60 cycles -> steps at edges 7, 23, 39, 55.
